control_mascara_cargador: RTL and testbench

Parametrised successor of the mask-control register block. It holds mask size and mask base address, programmed through the shared instruction register bus. On any effective change it runs a load sequence that reads N×N coefficients from the mask memory into an internal coefficient bank. It sits between the instruction decoder and the convolution datapath, which consumes the flattened coefficient bus once mascara_lista is high.

---
 rtl/control_mascara_cargador.sv | 186 ++++++++++++++++++
 tb/tb_control_mascara_cargador.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/control_mascara_cargador.sv
// control_mascara_cargador
// Holds the mask size and mask base address written over the instruction
// register bus and, whenever either changes (or a reload is requested),
// streams N*N coefficients from the mask memory into an internal bank.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   direccion_registros           register select (bits [1:0] decoded)
//   datos_registros               register write data
//   habilitacion_registros        one-cycle write strobe
//   mem_direccion, mem_lectura    mask memory read address / request
//   mem_datos                     read data, LATENCIA_MEM cycles after request
//   direccion_mem_inicio_mascara  programmed base address
//   tamano_mascara                programmed mask dimension N
//   mascara_coeficientes          flattened bank, slot k at [k*BC +: BC]
//   mascara_lista                 bank complete and consistent
//   ocupado                       load in progress
//   error_config                  sticky configuration error
module control_mascara_cargador #(
    parameter int BITS_BUS_DATOS_INSTR     = 24,
    parameter int BITS_BUS_DIRECCION_INSTR = 8,
    parameter int BITS_DIRECCION_MEM       = 10,
    parameter int BITS_MASCARA             = 3,
    parameter int BITS_COEFICIENTE         = 8,
    parameter int TAMANO_MAX_MASCARA       = 5,
    parameter int LATENCIA_MEM             = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [BITS_BUS_DIRECCION_INSTR-1:0]     direccion_registros,
    input  logic [BITS_BUS_DATOS_INSTR-1:0]         datos_registros,
    input  logic                                    habilitacion_registros,
    output logic [BITS_DIRECCION_MEM-1:0]           mem_direccion,
    output logic                                    mem_lectura,
    input  logic [BITS_COEFICIENTE-1:0]             mem_datos,
    output logic [BITS_DIRECCION_MEM-1:0]           direccion_mem_inicio_mascara,
    output logic [BITS_MASCARA-1:0]                 tamano_mascara,
    output logic [TAMANO_MAX_MASCARA*TAMANO_MAX_MASCARA*BITS_COEFICIENTE-1:0] mascara_coeficientes,
    output logic                                    mascara_lista,
    output logic                                    ocupado,
    output logic                                    error_config
);

    localparam int NSLOTS = TAMANO_MAX_MASCARA * TAMANO_MAX_MASCARA;
    localparam int CNT_W  = $clog2(NSLOTS + 1);
    localparam int SLOT_W = $clog2(NSLOTS);
    localparam logic [BITS_MASCARA-1:0] TAM_MAX   = BITS_MASCARA'(TAMANO_MAX_MASCARA);
    localparam logic [BITS_MASCARA-1:0] TAM_RESET = BITS_MASCARA'(3);

    typedef enum logic [1:0] {REPOSO, EMITIR, DRENAR} estado_t;

    estado_t                         estado_q, estado_d;
    logic [BITS_MASCARA-1:0]         tamano_q, tamano_d;
    logic [BITS_DIRECCION_MEM-1:0]   base_q, base_d;
    logic [CNT_W-1:0]                emit_q, emit_d;
    logic [CNT_W-1:0]                capt_q, capt_d;
    logic [LATENCIA_MEM-1:0]         vld_q, vld_d;
    logic [BITS_COEFICIENTE-1:0]     slots_q [NSLOTS];
    logic [BITS_COEFICIENTE-1:0]     slots_d [NSLOTS];
    logic                            lista_q, lista_d;
    logic                            error_q, error_d;

    logic                            wr_tamano, wr_base, wr_control;
    logic [BITS_MASCARA-1:0]         tamano_nuevo;
    logic [BITS_DIRECCION_MEM-1:0]   base_nueva;
    logic                            tamano_valido;
    logic                            carga;
    logic [CNT_W-1:0]                total;

    // Upper bus bits are not part of the register map.
    logic unused_bits;
    assign unused_bits = ^{datos_registros[BITS_BUS_DATOS_INSTR-1:BITS_DIRECCION_MEM],
                           direccion_registros[BITS_BUS_DIRECCION_INSTR-1:2]};

    assign wr_tamano     = habilitacion_registros && (direccion_registros[1:0] == 2'd0);
    assign wr_base       = habilitacion_registros && (direccion_registros[1:0] == 2'd1);
    assign wr_control    = habilitacion_registros && (direccion_registros[1:0] == 2'd2);
    assign tamano_nuevo  = datos_registros[BITS_MASCARA-1:0];
    assign base_nueva    = datos_registros[BITS_DIRECCION_MEM-1:0];
    // Odd implies nonzero, so bit0 covers both the parity and >=1 checks.
    assign tamano_valido = tamano_nuevo[0] && (tamano_nuevo <= TAM_MAX);
    assign total         = CNT_W'(tamano_q) * CNT_W'(tamano_q);

    // State / datapath register
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= REPOSO;
            tamano_q <= TAM_RESET;
            base_q   <= '0;
            emit_q   <= '0;
            capt_q   <= '0;
            vld_q    <= '0;
            lista_q  <= 1'b0;
            error_q  <= 1'b0;
            for (int i = 0; i < NSLOTS; i++) slots_q[i] <= '0;
        end else begin
            estado_q <= estado_d;
            tamano_q <= tamano_d;
            base_q   <= base_d;
            emit_q   <= emit_d;
            capt_q   <= capt_d;
            vld_q    <= vld_d;
            lista_q  <= lista_d;
            error_q  <= error_d;
            for (int i = 0; i < NSLOTS; i++) slots_q[i] <= slots_d[i];
        end
    end

    // Next state and register-file updates
    always_comb begin
        estado_d = estado_q;
        tamano_d = tamano_q;
        base_d   = base_q;
        emit_d   = emit_q;
        capt_d   = capt_q;
        lista_d  = lista_q;
        error_d  = error_q;
        carga    = 1'b0;
        for (int i = 0; i < NSLOTS; i++) slots_d[i] = slots_q[i];
        // Valid shift register tracks each read through the memory latency.
        vld_d = LATENCIA_MEM'({vld_q, mem_lectura});

        if (vld_q[LATENCIA_MEM-1]) begin
            slots_d[capt_q[SLOT_W-1:0]] = mem_datos;
            capt_d = capt_q + CNT_W'(1);
        end

        case (estado_q)
            REPOSO: begin
                if (wr_tamano) begin
                    if (tamano_valido) begin
                        tamano_d = tamano_nuevo;
                        if (tamano_nuevo != tamano_q) carga = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                if (wr_base) begin
                    base_d = base_nueva;
                    if (base_nueva != base_q) carga = 1'b1;
                end
                if (wr_control && datos_registros[0]) carga = 1'b1;
                if (carga) begin
                    estado_d = EMITIR;
                    emit_d   = '0;
                    capt_d   = '0;
                    lista_d  = 1'b0;
                    for (int i = 0; i < NSLOTS; i++) slots_d[i] = '0;
                end
            end
            EMITIR: begin
                emit_d = emit_q + CNT_W'(1);
                if (emit_q == total - CNT_W'(1)) estado_d = DRENAR;
            end
            DRENAR: begin
                if (capt_q == total) begin
                    estado_d = REPOSO;
                    lista_d  = 1'b1;
                end
            end
            default: estado_d = REPOSO;
        endcase

        // Size/base cannot change under a running load.
        if ((estado_q != REPOSO) && (wr_tamano || wr_base)) error_d = 1'b1;
        if (wr_control && datos_registros[1]) error_d = 1'b0;
    end

    // Outputs
    always_comb begin
        mem_lectura   = (estado_q == EMITIR);
        mem_direccion = '0;
        if (estado_q == EMITIR) mem_direccion = base_q + BITS_DIRECCION_MEM'(emit_q);
        ocupado       = (estado_q != REPOSO);
    end

    assign direccion_mem_inicio_mascara = base_q;
    assign tamano_mascara               = tamano_q;
    assign mascara_lista                = lista_q;
    assign error_config                 = error_q;

    for (genvar g = 0; g < NSLOTS; g++) begin : g_plano
        assign mascara_coeficientes[g*BITS_COEFICIENTE +: BITS_COEFICIENTE] = slots_q[g];
    end

endmodule

// File: tb/tb_control_mascara_cargador.sv
module tb_control_mascara_cargador;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  direccion_registros = '0;
    logic [23:0] datos_registros = '0;
    logic        habilitacion_registros = 1'b0;
    logic [9:0]  mem_direccion;
    logic        mem_lectura;
    logic [7:0]  mem_datos = '0;
    logic [9:0]  direccion_mem_inicio_mascara;
    logic [2:0]  tamano_mascara;
    logic [199:0] mascara_coeficientes;
    logic        mascara_lista;
    logic        ocupado;
    logic        error_config;

    int checks = 0;
    int errors = 0;

    control_mascara_cargador dut (
        .clk                          (clk),
        .reset                        (reset),
        .direccion_registros          (direccion_registros),
        .datos_registros              (datos_registros),
        .habilitacion_registros       (habilitacion_registros),
        .mem_direccion                (mem_direccion),
        .mem_lectura                  (mem_lectura),
        .mem_datos                    (mem_datos),
        .direccion_mem_inicio_mascara (direccion_mem_inicio_mascara),
        .tamano_mascara               (tamano_mascara),
        .mascara_coeficientes         (mascara_coeficientes),
        .mascara_lista                (mascara_lista),
        .ocupado                      (ocupado),
        .error_config                 (error_config)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory returning the low address byte.
    always @(posedge clk) if (mem_lectura) mem_datos <= mem_direccion[7:0];

    function automatic logic [7:0] slot(input int k);
        return mascara_coeficientes[k*8 +: 8];
    endfunction

    // Called at a negedge; returns at the negedge right after the write edge.
    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        direccion_registros = {6'd0, a};
        datos_registros = d;
        habilitacion_registros = 1'b1;
        @(negedge clk);
        habilitacion_registros = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (tamano_mascara !== 3'd3) begin errors++; $display("FAIL reset_size got %0d exp 3", tamano_mascara); end
        checks++; if (direccion_mem_inicio_mascara !== 10'd0) begin errors++; $display("FAIL reset_base got %h exp 0", direccion_mem_inicio_mascara); end
        checks++; if (mascara_coeficientes !== '0) begin errors++; $display("FAIL reset_slots got %h exp 0", mascara_coeficientes); end
        checks++; if ({mascara_lista, ocupado, mem_lectura, error_config} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {mascara_lista, ocupado, mem_lectura, error_config}); end
        checks++; if (mem_direccion !== 10'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_direccion); end
    endtask

    task automatic test_base_load;
        logic [9:0] ea;
        wr(2'd1, 24'h040);
        for (int c = 0; c <= 11; c++) begin
            ea = (c < 9) ? 10'(10'h040 + c) : 10'd0;
            checks++; if (mem_lectura !== (c < 9)) begin errors++; $display("FAIL base_load_rd c=%0d got %b exp %b", c, mem_lectura, (c < 9)); end
            checks++; if (mem_direccion !== ea) begin errors++; $display("FAIL base_load_addr c=%0d got %h exp %h", c, mem_direccion, ea); end
            checks++; if (ocupado !== (c < 11)) begin errors++; $display("FAIL base_load_busy c=%0d got %b exp %b", c, ocupado, (c < 11)); end
            checks++; if (mascara_lista !== (c >= 11)) begin errors++; $display("FAIL base_load_ready c=%0d got %b exp %b", c, mascara_lista, (c >= 11)); end
            @(negedge clk);
        end
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (slot(k) !== ((k < 9) ? 8'(8'h40 + k) : 8'h00)) begin
                errors++; $display("FAIL base_load_slot k=%0d got %h exp %h", k, slot(k), (k < 9) ? 8'(8'h40 + k) : 8'h00);
            end
        end
    endtask

    task automatic test_size_error;
        wr(2'd0, 24'd4);
        checks++; if (tamano_mascara !== 3'd3) begin errors++; $display("FAIL size4_kept got %0d exp 3", tamano_mascara); end
        checks++; if (error_config !== 1'b1) begin errors++; $display("FAIL size4_err got %b exp 1", error_config); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL size4_noload got %b exp 0", ocupado); end
        wr(2'd2, 24'h2);
        checks++; if (error_config !== 1'b0) begin errors++; $display("FAIL err_clear1 got %b exp 0", error_config); end
        wr(2'd0, 24'd7);
        checks++; if (tamano_mascara !== 3'd3) begin errors++; $display("FAIL size7_kept got %0d exp 3", tamano_mascara); end
        checks++; if ({error_config, ocupado} !== 2'b10) begin errors++; $display("FAIL size7_flags got %b exp 10", {error_config, ocupado}); end
        wr(2'd2, 24'h2);
        checks++; if (error_config !== 1'b0) begin errors++; $display("FAIL err_clear2 got %b exp 0", error_config); end
        wr(2'd0, 24'd3);
        checks++; if ({ocupado, mem_lectura, error_config, mascara_lista} !== 4'b0001) begin errors++; $display("FAIL same_size got %b exp 0001", {ocupado, mem_lectura, error_config, mascara_lista}); end
    endtask

    task automatic test_wrap;
        logic [9:0] ea;
        wr(2'd1, 24'h3FE);
        for (int c = 0; c <= 11; c++) begin
            ea = (c < 9) ? 10'(10'h3FE + c) : 10'd0;
            checks++; if (mem_direccion !== ea) begin errors++; $display("FAIL wrap_addr c=%0d got %h exp %h", c, mem_direccion, ea); end
            checks++; if (mascara_lista !== (c >= 11)) begin errors++; $display("FAIL wrap_ready c=%0d got %b exp %b", c, mascara_lista, (c >= 11)); end
            @(negedge clk);
        end
        for (int k = 0; k < 9; k++) begin
            ea = 10'(10'h3FE + k);
            checks++; if (slot(k) !== ea[7:0]) begin errors++; $display("FAIL wrap_slot k=%0d got %h exp %h", k, slot(k), ea[7:0]); end
        end
    endtask

    task automatic test_write_busy;
        logic [9:0] ea;
        wr(2'd1, 24'h120);
        for (int c = 0; c <= 11; c++) begin
            if (c == 2) begin
                direccion_registros = 8'd1; datos_registros = 24'h200; habilitacion_registros = 1'b1;
            end else begin
                habilitacion_registros = 1'b0;
            end
            ea = (c < 9) ? 10'(10'h120 + c) : 10'd0;
            checks++; if (mem_direccion !== ea) begin errors++; $display("FAIL busy_addr c=%0d got %h exp %h", c, mem_direccion, ea); end
            checks++; if (mascara_lista !== (c >= 11)) begin errors++; $display("FAIL busy_ready c=%0d got %b exp %b", c, mascara_lista, (c >= 11)); end
            @(negedge clk);
        end
        checks++; if (direccion_mem_inicio_mascara !== 10'h120) begin errors++; $display("FAIL busy_base got %h exp 120", direccion_mem_inicio_mascara); end
        checks++; if (error_config !== 1'b1) begin errors++; $display("FAIL busy_err got %b exp 1", error_config); end
        checks++; if (slot(8) !== 8'h28) begin errors++; $display("FAIL busy_slot8 got %h exp 28", slot(8)); end
        wr(2'd2, 24'h1);
        for (int c = 0; c <= 11; c++) begin
            ea = (c < 9) ? 10'(10'h120 + c) : 10'd0;
            checks++; if (mem_direccion !== ea) begin errors++; $display("FAIL reload_addr c=%0d got %h exp %h", c, mem_direccion, ea); end
            checks++; if (mascara_lista !== (c >= 11)) begin errors++; $display("FAIL reload_ready c=%0d got %b exp %b", c, mascara_lista, (c >= 11)); end
            @(negedge clk);
        end
        wr(2'd2, 24'h2);
        checks++; if (error_config !== 1'b0) begin errors++; $display("FAIL busy_err_clear got %b exp 0", error_config); end
    endtask

    task automatic test_size5;
        logic [9:0] ea;
        wr(2'd0, 24'd5);
        for (int c = 0; c <= 27; c++) begin
            ea = (c < 25) ? 10'(10'h120 + c) : 10'd0;
            checks++; if (mem_lectura !== (c < 25)) begin errors++; $display("FAIL size5_rd c=%0d got %b exp %b", c, mem_lectura, (c < 25)); end
            checks++; if (mem_direccion !== ea) begin errors++; $display("FAIL size5_addr c=%0d got %h exp %h", c, mem_direccion, ea); end
            checks++; if (mascara_lista !== (c >= 27)) begin errors++; $display("FAIL size5_ready c=%0d got %b exp %b", c, mascara_lista, (c >= 27)); end
            @(negedge clk);
        end
        for (int k = 0; k < 25; k++) begin
            checks++; if (slot(k) !== 8'(8'h20 + k)) begin errors++; $display("FAIL size5_slot k=%0d got %h exp %h", k, slot(k), 8'(8'h20 + k)); end
        end
        wr(2'd0, 24'd5);
        repeat (2) begin
            checks++; if ({ocupado, mem_lectura, mascara_lista, error_config} !== 4'b0010) begin errors++; $display("FAIL size5_rewrite got %b exp 0010", {ocupado, mem_lectura, mascara_lista, error_config}); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midload;
        wr(2'd2, 24'h1);
        repeat (4) @(negedge clk);
        checks++; if ({mem_lectura, mem_direccion} !== {1'b1, 10'h124}) begin errors++; $display("FAIL midload_read4 got %b/%h exp 1/124", mem_lectura, mem_direccion); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({mascara_lista, ocupado, mem_lectura, error_config} !== 4'b0000) begin errors++; $display("FAIL midload_flags got %b exp 0000", {mascara_lista, ocupado, mem_lectura, error_config}); end
        checks++; if ({tamano_mascara, direccion_mem_inicio_mascara, mem_direccion} !== {3'd3, 10'd0, 10'd0}) begin errors++; $display("FAIL midload_regs got %0d/%h/%h exp 3/0/0", tamano_mascara, direccion_mem_inicio_mascara, mem_direccion); end
        checks++; if (mascara_coeficientes !== '0) begin errors++; $display("FAIL midload_slots got %h exp 0", mascara_coeficientes); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if ({mem_lectura, ocupado} !== 2'b00) begin errors++; $display("FAIL midload_idle c=%0d got %b exp 00", c, {mem_lectura, ocupado}); end
            checks++; if (mascara_coeficientes !== '0) begin errors++; $display("FAIL midload_discard c=%0d got %h exp 0", c, mascara_coeficientes); end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_base_load();
        test_size_error();
        test_wrap();
        test_write_busy();
        test_size5();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
